register_file: RTL and testbench



---
 rtl/register_file_if.sv | 28 ++
 rtl/register_file.sv | 55 +++++
 tb/tb_register_file.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Bus bundle between the datapath/fetch stage (master) and the ARM register file (slave).
// Holds one writeback port, three read ports and the dedicated R15/PC load path.
interface register_file_if #(
    parameter int DATA_W = 32
);
    logic              LE;
    logic [3:0]        RW;
    logic [DATA_W-1:0] PW;
    logic [3:0]        RA;
    logic [3:0]        RB;
    logic [3:0]        RD;
    logic [DATA_W-1:0] PA;
    logic [DATA_W-1:0] PB;
    logic [DATA_W-1:0] PD;
    logic              LE_PC;
    logic [DATA_W-1:0] PC_IN;
    logic [DATA_W-1:0] PC_OUT;

    modport master (
        output LE, RW, PW, RA, RB, RD, LE_PC, PC_IN,
        input  PA, PB, PD, PC_OUT
    );

    modport slave (
        input  LE, RW, PW, RA, RB, RD, LE_PC, PC_IN,
        output PA, PB, PD, PC_OUT
    );
endinterface

// File: rtl/register_file.sv
// Sixteen-entry ARM register file R0-R15 with three combinational read ports.
// R15 is the PC: a writeback to R15 takes priority over the fetch-stage PC load.
module register_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    register_file_if.slave bus
);
    localparam int PC_IDX = NREGS - 1;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  wrDec;
    logic [NREGS-1:0]  loadEn;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            wrDec[i] = bus.LE && (bus.RW == 4'(i));
        end
    end

    // R15 loads from the writeback port when addressed, otherwise from fetch.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = bus.PW;
            loadEn[i] = wrDec[i];
        end
        if (!wrDec[PC_IDX]) begin
            regs_d[PC_IDX] = bus.PC_IN;
        end
        loadEn[PC_IDX] = wrDec[PC_IDX] || bus.LE_PC;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (loadEn[i]) begin
                    regs_q[i] <= regs_d[i];
                end
            end
        end
    end

    // No write-through bypass: reads always see the pre-edge contents.
    assign bus.PA     = regs_q[bus.RA];
    assign bus.PB     = regs_q[bus.RB];
    assign bus.PD     = regs_q[bus.RD];
    assign bus.PC_OUT = regs_q[PC_IDX];
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array model updated from the architectural write rules.
module tb_register_file;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [31:0] model [16];

    register_file_if #(.DATA_W(32)) bus ();

    register_file #(.DATA_W(32), .NREGS(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and apply the architectural update to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) model[i] = 32'h0;
        end else begin
            if (bus.LE) model[bus.RW] = bus.PW;
            if (bus.LE_PC && !(bus.LE && bus.RW == 4'd15)) model[15] = bus.PC_IN;
        end
        #1;
    endtask

    task automatic idle();
        bus.LE = 1'b0; bus.RW = '0; bus.PW = '0;
        bus.LE_PC = 1'b0; bus.PC_IN = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.LE = 1'b1; bus.RW = 4'(i); bus.PW = 32'hFFFF_FFFF;
            tick();
        end
        bus.RA = 4'd9; #1;
        checks++;
        if (bus.PA !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL preload got %h expected %h", bus.PA, 32'hFFFF_FFFF);
        end
        reset_n = 1'b0;
        bus.LE = 1'b1; bus.RW = 4'd3; bus.PW = 32'h1234_5678;
        tick();
        reset_n = 1'b1;
        idle();
        for (int i = 0; i < 16; i++) begin
            bus.RA = 4'(i); bus.RB = 4'(i); bus.RD = 4'(i); #1;
            checks++;
            if (bus.PA !== 32'h0 || bus.PB !== 32'h0 || bus.PD !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_R%0d got %h/%h/%h expected 0", i, bus.PA, bus.PB, bus.PD);
            end
        end
        checks++;
        if (bus.PC_OUT !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_pc got %h expected 0", bus.PC_OUT);
        end
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 15; k++) begin
            bus.LE = 1'b1; bus.RW = 4'(k); bus.PW = 32'h1000_0000 + 32'(k);
            bus.RA = 4'(k); #1;
            checks++;
            if (bus.PA !== 32'h0) begin
                errors++; $display("[TB] FAIL rdw_old_R%0d got %h expected %h", k, bus.PA, 32'h0);
            end
            tick();
        end
        idle();
        for (int k = 0; k < 15; k++) begin
            bus.RA = 4'(k); bus.RB = 4'(k); bus.RD = 4'(k); #1;
            checks++;
            if (bus.PA !== 32'h1000_0000 + 32'(k) || bus.PB !== 32'h1000_0000 + 32'(k) ||
                bus.PD !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("[TB] FAIL sweep_R%0d got %h/%h/%h expected %h", k, bus.PA, bus.PB, bus.PD,
                         32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_hold();
        bus.LE = 1'b0; bus.RW = 4'd5; bus.PW = 32'hDEAD_BEEF;
        tick();
        idle();
        bus.RA = 4'd5; #1;
        checks++;
        if (bus.PA !== 32'h1000_0005) begin
            errors++; $display("[TB] FAIL hold_R5 got %h expected %h", bus.PA, 32'h1000_0005);
        end
    endtask

    task automatic test_pc_path();
        logic [31:0] seq [3];
        seq[0] = 32'h4; seq[1] = 32'h8; seq[2] = 32'hC;
        bus.RA = 4'd15;
        for (int i = 0; i < 3; i++) begin
            bus.LE_PC = 1'b1; bus.PC_IN = seq[i]; #1;
            checks++;
            if (bus.PC_OUT !== model[15]) begin
                errors++; $display("[TB] FAIL pc_pre%0d got %h expected %h", i, bus.PC_OUT, model[15]);
            end
            tick();
            checks++;
            if (bus.PC_OUT !== seq[i] || bus.PA !== seq[i]) begin
                errors++;
                $display("[TB] FAIL pc_load%0d got %h/%h expected %h", i, bus.PC_OUT, bus.PA, seq[i]);
            end
        end
        idle();
    endtask

    task automatic test_pc_priority();
        bus.LE = 1'b1; bus.RW = 4'd15; bus.PW = 32'h200;
        bus.LE_PC = 1'b1; bus.PC_IN = 32'h10;
        tick();
        checks++;
        if (bus.PC_OUT !== 32'h200) begin
            errors++; $display("[TB] FAIL pc_priority got %h expected %h", bus.PC_OUT, 32'h200);
        end
        bus.RW = 4'd2; bus.PW = 32'hAA; bus.PC_IN = 32'h14;
        tick();
        idle();
        bus.RA = 4'd2; #1;
        checks++;
        if (bus.PA !== 32'hAA || bus.PC_OUT !== 32'h14) begin
            errors++;
            $display("[TB] FAIL pc_dual got R2=%h R15=%h expected R2=%h R15=%h", bus.PA, bus.PC_OUT,
                     32'hAA, 32'h14);
        end
    endtask

    task automatic test_port_independence();
        bus.LE = 1'b1; bus.RW = 4'd7; bus.PW = 32'hCAFE_F00D;
        tick();
        idle();
        bus.RA = 4'd7; bus.RB = 4'd7; bus.RD = 4'd7; #1;
        checks++;
        if (bus.PA !== 32'hCAFE_F00D || bus.PB !== 32'hCAFE_F00D || bus.PD !== 32'hCAFE_F00D) begin
            errors++;
            $display("[TB] FAIL same_sel got %h/%h/%h expected %h", bus.PA, bus.PB, bus.PD, 32'hCAFE_F00D);
        end
        bus.RA = 4'd0; bus.RB = 4'd7; bus.RD = 4'd15; #1;
        checks++;
        if (bus.PA !== 32'h1000_0000 || bus.PB !== 32'hCAFE_F00D || bus.PD !== 32'h14) begin
            errors++;
            $display("[TB] FAIL mixed_sel got %h/%h/%h expected %h/%h/%h", bus.PA, bus.PB, bus.PD,
                     32'h1000_0000, 32'hCAFE_F00D, 32'h14);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset_n    = ($urandom_range(0, 59) != 0);
            bus.LE     = $urandom_range(0, 1) != 0;
            bus.RW     = 4'($urandom_range(0, 15));
            bus.PW     = $urandom;
            bus.LE_PC  = $urandom_range(0, 2) == 0;
            bus.PC_IN  = $urandom;
            bus.RA     = 4'($urandom_range(0, 15));
            bus.RB     = 4'($urandom_range(0, 15));
            bus.RD     = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (bus.PA !== model[bus.RA] || bus.PB !== model[bus.RB] || bus.PD !== model[bus.RD] ||
                bus.PC_OUT !== model[15]) begin
                errors++;
                $display("[TB] FAIL random%0d got %h/%h/%h/%h expected %h/%h/%h/%h", n,
                         bus.PA, bus.PB, bus.PD, bus.PC_OUT,
                         model[bus.RA], model[bus.RB], model[bus.RD], model[15]);
            end
            tick();
        end
        reset_n = 1'b1;
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        reset_n = 1'b0;
        bus.RA = '0; bus.RB = '0; bus.RD = '0;
        idle();
        test_reset();
        test_write_read();
        test_hold();
        test_pc_path();
        test_pc_priority();
        test_port_independence();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
